instr_sequencer: RTL and testbench

Multi-cycle control stage that sits directly upstream of the 8×32 register array. It accepts one 16-bit register-to-register instruction at a time over a valid/ready handshake and drives the register array's two read addresses. It captures the returned operands, computes the result in an internal ALU, and issues a single write-back with `write_en`-style strobe timing that matches the array's falling-edge write.

---
 rtl/instr_sequencer_pkg.sv | 42 ++++
 rtl/instr_sequencer_if.sv | 33 +++
 rtl/seq_alu.sv | 34 +++
 rtl/instr_sequencer.sv | 99 +++++++++
 tb/tb_instr_sequencer.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: opcodes, FSM encoding,
// instruction field positions and opcode classification helpers.
// No ports; imported by seq_alu and instr_sequencer.
package seq_pkg;

    // Opcodes (instr[15:12]); 8..15 are undefined
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLT  = 4'd5;
    localparam logic [3:0] OP_ADDI = 4'd6;
    localparam logic [3:0] OP_NOP  = 4'd7;

    // FSM state encoding (binary)
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_READ   = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;

    // Instruction field positions
    localparam int INSTR_W = 16;
    localparam int OPC_LSB = 12;
    localparam int OPC_W   = 4;
    localparam int RD_LSB  = 9;
    localparam int RS1_LSB = 6;
    localparam int RS2_LSB = 3;
    localparam int IMM_LSB = 0;
    localparam int IMM_W   = 6;

    // Opcodes 0..6 produce a register write; NOP and undefined ones do not
    function automatic logic op_writes(input logic [3:0] op);
        return (op <= OP_ADDI);
    endfunction

    function automatic logic op_illegal(input logic [3:0] op);
        return op[3];
    endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Bundle between the sequencer and its environment: instruction handshake,
// register-array read/write ports and status pulses.
// slave = sequencer side, master = upstream/register-array side.
interface instr_sequencer_if #(
    parameter int BITS_DATA = 32,
    parameter int BITS_ADDR = 3
);
    logic                 instr_valid;
    logic                 instr_ready;
    logic [15:0]          instr;
    logic [BITS_ADDR-1:0] rf_raddr1;
    logic [BITS_ADDR-1:0] rf_raddr2;
    logic [BITS_DATA-1:0] rf_rdata1;
    logic [BITS_DATA-1:0] rf_rdata2;
    logic [BITS_ADDR-1:0] rf_waddr;
    logic [BITS_DATA-1:0] rf_wdata;
    logic                 rf_we;
    logic                 busy;
    logic                 done;
    logic                 illegal;

    modport master (
        output instr_valid, instr, rf_rdata1, rf_rdata2,
        input  instr_ready, rf_raddr1, rf_raddr2, rf_waddr, rf_wdata, rf_we,
               busy, done, illegal
    );

    modport slave (
        input  instr_valid, instr, rf_rdata1, rf_rdata2,
        output instr_ready, rf_raddr1, rf_raddr2, rf_waddr, rf_wdata, rf_we,
               busy, done, illegal
    );
endinterface

// File: rtl/seq_alu.sv
// Combinational ALU for the sequencer: ADD/SUB/AND/OR/XOR/SLT/ADDI.
// Latency 0 (pure combinational); no flow control.
// Ports: op, a, b, imm6 in; result out. NOP/undefined opcodes give 0.
module seq_alu
    import seq_pkg::*;
#(
    parameter int BITS_DATA = 32
) (
    input  logic [3:0]           op,
    input  logic [BITS_DATA-1:0] a,
    input  logic [BITS_DATA-1:0] b,
    input  logic [IMM_W-1:0]     imm6,
    output logic [BITS_DATA-1:0] result
);
    logic [BITS_DATA-1:0] imm_ext;
    logic                 slt;

    assign imm_ext = {{(BITS_DATA-IMM_W){imm6[IMM_W-1]}}, imm6};
    assign slt     = ($signed(a) < $signed(b));

    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SLT:  result = {{(BITS_DATA-1){1'b0}}, slt};
            OP_ADDI: result = a + imm_ext;
            default: result = '0;
        endcase
    end
endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle sequencer: accepts one instruction, reads two registers, executes, writes back.
// Latency: accept edge = cycle 0, write-back/done in cycle 4; one instruction per 5 cycles.
// Backpressure: instr_ready high only in IDLE; ports clk, rst_n, bus (slave modport).
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int BITS_DATA = 32,
    parameter int BITS_ADDR = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    instr_sequencer_if.slave  bus
);
    logic [2:0]           state_q;
    logic [OPC_W-1:0]     op_q;
    logic [BITS_ADDR-1:0] rd_q;
    logic [IMM_W-1:0]     imm_q;
    logic                 wr_q;
    logic                 ill_q;
    logic [BITS_DATA-1:0] a_q;
    logic [BITS_DATA-1:0] b_q;
    logic [BITS_DATA-1:0] alu_result;
    logic                 accept;

    assign bus.instr_ready = (state_q == ST_IDLE);
    assign bus.busy        = (state_q != ST_IDLE);
    assign accept          = bus.instr_valid && bus.instr_ready;

    seq_alu #(.BITS_DATA(BITS_DATA)) u_alu (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .imm6   (imm_q),
        .result (alu_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            op_q          <= '0;
            rd_q          <= '0;
            imm_q         <= '0;
            wr_q          <= 1'b0;
            ill_q         <= 1'b0;
            a_q           <= '0;
            b_q           <= '0;
            bus.rf_raddr1 <= '0;
            bus.rf_raddr2 <= '0;
            bus.rf_waddr  <= '0;
            bus.rf_wdata  <= '0;
            bus.rf_we     <= 1'b0;
            bus.done      <= 1'b0;
            bus.illegal   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        op_q          <= bus.instr[OPC_LSB +: OPC_W];
                        rd_q          <= bus.instr[RD_LSB +: BITS_ADDR];
                        imm_q         <= bus.instr[IMM_LSB +: IMM_W];
                        // Read addresses go out straight from the accepted word so
                        // they are valid during DECODE; the array latches them on
                        // the edge ending DECODE and its output settles in READ.
                        bus.rf_raddr1 <= bus.instr[RS1_LSB +: BITS_ADDR];
                        bus.rf_raddr2 <= bus.instr[RS2_LSB +: BITS_ADDR];
                        state_q       <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    wr_q    <= op_writes(op_q);
                    ill_q   <= op_illegal(op_q);
                    state_q <= ST_READ;
                end
                ST_READ: begin
                    a_q     <= bus.rf_rdata1;
                    b_q     <= bus.rf_rdata2;
                    state_q <= ST_EXEC;
                end
                ST_EXEC: begin
                    // All write-side outputs are registered here, so they are
                    // stable for the whole WB cycle including its falling edge.
                    bus.rf_wdata <= alu_result;
                    bus.rf_waddr <= rd_q;
                    bus.rf_we    <= wr_q;
                    bus.done     <= 1'b1;
                    bus.illegal  <= ill_q;
                    state_q      <= ST_WB;
                end
                ST_WB: begin
                    bus.rf_we   <= 1'b0;
                    bus.done    <= 1'b0;
                    bus.illegal <= 1'b0;
                    state_q     <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;
    logic clk;
    logic rst_n;
    logic load_regs;
    logic [31:0] regs     [0:7];
    logic [31:0] exp_regs [0:7];
    int n_checks;
    int n_fail;

    instr_sequencer_if #(.BITS_DATA(32), .BITS_ADDR(3)) bus ();

    instr_sequencer #(.BITS_DATA(32), .BITS_ADDR(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 8x32 register array: rising-edge read, falling-edge write
    always @(posedge clk) begin
        bus.rf_rdata1 <= regs[bus.rf_raddr1];
        bus.rf_rdata2 <= regs[bus.rf_raddr2];
    end

    always @(negedge clk) begin
        if (load_regs) begin
            regs[0] <= 32'hDEAD_BEEF;
            regs[1] <= 32'd5;
            regs[2] <= 32'd7;
            regs[3] <= 32'hFFFF_FFFF;
            regs[4] <= 32'd0;
            regs[5] <= 32'd0;
            regs[6] <= 32'd0;
            regs[7] <= 32'd0;
        end else if (bus.rf_we) begin
            regs[bus.rf_waddr] <= bus.rf_wdata;
        end
    end

    function automatic logic [15:0] enc(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs1, input logic [2:0] rs2);
        return {op, rd, rs1, rs2, 3'b000};
    endfunction

    function automatic logic [15:0] enc_i(input logic [2:0] rd, input logic [2:0] rs1,
                                          input logic [5:0] imm);
        return {4'd6, rd, rs1, imm};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one instruction on cycle 0 and return sampling inside cycle 4
    task automatic issue(input logic [15:0] ins);
        bus.instr       = ins;
        bus.instr_valid = 1'b1;
        tick();
        bus.instr_valid = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        repeat (2) tick();
        n_checks++; if (bus.instr_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b want 1", bus.instr_ready); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", bus.busy); end
        n_checks++; if ({bus.done, bus.illegal, bus.rf_we} !== 3'b000) begin n_fail++; $display("FAIL rst_pulses got %b want 000", {bus.done, bus.illegal, bus.rf_we}); end
        n_checks++; if ({bus.rf_raddr1, bus.rf_raddr2, bus.rf_waddr, bus.rf_wdata} !== 41'd0) begin n_fail++; $display("FAIL rst_bus got %h want 0", {bus.rf_raddr1, bus.rf_raddr2, bus.rf_waddr, bus.rf_wdata}); end
        // Release reset with a NOP already offered: accepted on first edge
        bus.instr       = enc(4'd7, 3'd4, 3'd1, 3'd2);
        bus.instr_valid = 1'b1;
        rst_n           = 1'b1;
        tick();
        bus.instr_valid = 1'b0;
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL rel_accept busy got %b want 1", bus.busy); end
        repeat (3) tick();
        n_checks++; if ({bus.done, bus.illegal, bus.rf_we} !== 3'b100) begin n_fail++; $display("FAIL nop_wb done/ill/we got %b want 100", {bus.done, bus.illegal, bus.rf_we}); end
        tick();
        n_checks++; if (regs[4] !== 32'd0) begin n_fail++; $display("FAIL nop_nowrite R4 got %h want 0", regs[4]); end
    endtask

    task automatic test_add();
        n_checks++; if (bus.instr_ready !== 1'b1) begin n_fail++; $display("FAIL add_c0_ready got %b want 1", bus.instr_ready); end
        bus.instr       = enc(4'd0, 3'd4, 3'd1, 3'd2);
        bus.instr_valid = 1'b1;
        tick();
        bus.instr_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            n_checks++; if (bus.instr_ready !== 1'b0) begin n_fail++; $display("FAIL add_ready_c%0d got %b want 0", c, bus.instr_ready); end
            n_checks++; if (bus.done !== (c == 4)) begin n_fail++; $display("FAIL add_done_c%0d got %b want %b", c, bus.done, (c == 4)); end
            if (c < 4) tick();
        end
        n_checks++; if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 3'd4, 32'd12}) begin n_fail++; $display("FAIL add_wb we/waddr/wdata got %b/%0d/%h want 1/4/c", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
        tick();
        n_checks++; if ({bus.instr_ready, bus.done, bus.rf_we} !== 3'b100) begin n_fail++; $display("FAIL add_c5 ready/done/we got %b want 100", {bus.instr_ready, bus.done, bus.rf_we}); end
        n_checks++; if (regs[4] !== 32'd12) begin n_fail++; $display("FAIL add_r4 got %h want c", regs[4]); end
        exp_regs[4] = 32'd12;
    endtask

    task automatic test_slt_sub();
        issue(enc(4'd5, 3'd5, 3'd3, 3'd1));
        tick();
        n_checks++; if (regs[5] !== 32'd1) begin n_fail++; $display("FAIL slt_r5 got %h want 1", regs[5]); end
        exp_regs[5] = 32'd1;
        issue(enc(4'd1, 3'd6, 3'd1, 3'd2));
        tick();
        n_checks++; if (regs[6] !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL sub_r6 got %h want fffffffe", regs[6]); end
        exp_regs[6] = 32'hFFFF_FFFE;
    endtask

    task automatic test_addi();
        issue(enc_i(3'd7, 3'd1, 6'h3F));
        tick();
        n_checks++; if (regs[7] !== 32'd4) begin n_fail++; $display("FAIL addi_neg_r7 got %h want 4", regs[7]); end
        exp_regs[7] = 32'd4;
        issue(enc_i(3'd0, 3'd3, 6'h01));
        n_checks++; if ({bus.rf_we, bus.rf_waddr} !== {1'b1, 3'd0}) begin n_fail++; $display("FAIL addi_r0_we got %b/%0d want 1/0", bus.rf_we, bus.rf_waddr); end
        tick();
        n_checks++; if (regs[0] !== 32'd0) begin n_fail++; $display("FAIL addi_wrap_r0 got %h want 0", regs[0]); end
        exp_regs[0] = 32'd0;
    endtask

    task automatic test_illegal();
        issue(enc(4'hB, 3'd2, 3'd1, 3'd1));
        n_checks++; if ({bus.done, bus.illegal, bus.rf_we} !== 3'b110) begin n_fail++; $display("FAIL ill_wb done/ill/we got %b want 110", {bus.done, bus.illegal, bus.rf_we}); end
        tick();
        n_checks++; if ({bus.done, bus.illegal} !== 2'b00) begin n_fail++; $display("FAIL ill_pulse got %b want 00", {bus.done, bus.illegal}); end
        n_checks++; if (regs[2] !== 32'd7) begin n_fail++; $display("FAIL ill_r2 got %h want 7", regs[2]); end
    endtask

    task automatic test_back_to_back();
        bus.instr       = enc(4'd0, 3'd1, 3'd1, 3'd1);
        bus.instr_valid = 1'b1;
        tick();
        repeat (3) tick();
        n_checks++; if ({bus.instr_ready, bus.done} !== 2'b01) begin n_fail++; $display("FAIL b2b_c4 ready/done got %b want 01", {bus.instr_ready, bus.done}); end
        tick();
        n_checks++; if (bus.instr_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_c5_ready got %b want 1", bus.instr_ready); end
        tick();
        bus.instr_valid = 1'b0;
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_second_accept busy got %b want 1", bus.busy); end
        repeat (3) tick();
        n_checks++; if ({bus.done, bus.rf_wdata} !== {1'b1, 32'd20}) begin n_fail++; $display("FAIL b2b_wb done/wdata got %b/%h want 1/14", bus.done, bus.rf_wdata); end
        tick();
        n_checks++; if (regs[1] !== 32'd20) begin n_fail++; $display("FAIL b2b_r1 got %h want 14", regs[1]); end
        exp_regs[1] = 32'd20;
    endtask

    task automatic test_reset_mid();
        int seen;
        seen = 0;
        bus.instr       = enc(4'd0, 3'd4, 3'd1, 3'd2);
        bus.instr_valid = 1'b1;
        tick();
        bus.instr_valid = 1'b0;
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        n_checks++; if ({bus.busy, bus.instr_ready, bus.rf_we, bus.done} !== 4'b0100) begin n_fail++; $display("FAIL mid_rst busy/ready/we/done got %b want 0100", {bus.busy, bus.instr_ready, bus.rf_we, bus.done}); end
        #1;
        rst_n = 1'b1;
        tick();
        n_checks++; if ({bus.instr_ready, bus.busy} !== 2'b10) begin n_fail++; $display("FAIL mid_rel ready/busy got %b want 10", {bus.instr_ready, bus.busy}); end
        for (int c = 0; c < 5; c++) begin
            if (bus.done || bus.rf_we) seen++;
            tick();
        end
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL mid_no_done cycles_with_done_or_we got %0d want 0", seen); end
        n_checks++; if (regs[4] !== 32'd12) begin n_fail++; $display("FAIL mid_r4 got %h want c", regs[4]); end
    endtask

    task automatic test_final_regs();
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (regs[i] !== exp_regs[i]) begin n_fail++; $display("FAIL final_r%0d got %h want %h", i, regs[i], exp_regs[i]); end
        end
    endtask

    initial begin
        n_checks        = 0;
        n_fail          = 0;
        rst_n           = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr       = 16'h0000;
        load_regs       = 1'b1;
        exp_regs[0] = 32'hDEAD_BEEF; exp_regs[1] = 32'd5; exp_regs[2] = 32'd7; exp_regs[3] = 32'hFFFF_FFFF;
        exp_regs[4] = 32'd0; exp_regs[5] = 32'd0; exp_regs[6] = 32'd0; exp_regs[7] = 32'd0;
        #1 rst_n = 1'b0;
        @(negedge clk);
        #1 load_regs = 1'b0;
        test_reset();
        test_add();
        test_slt_sub();
        test_addi();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        test_final_regs();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
